dm_sba: RTL and testbench
=========================

// Module: dm_sba
// PURPOSE
// - Debug Module System Bus Access (SBA) controller for the single-hart DM.
// - Owns the sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3C) registers behind the DMI register port.
// - Sequences single 8/16/32-bit transactions onto the system bus via a req/gnt/rvalid handshake.
// - Implements busy, error, autoincrement, readonaddr and readondata as in RISC-V debug spec 0.13.
// PARAMETERS
// - AW   32   system bus address width; also reported in sbcs.sbasize.
// PORTS
// - clk        in   1   clock
// - rst        in   1   async reset, active-high
// - reg_wr     in   1   1-cycle DMI write strobe
// - reg_rd     in   1   1-cycle DMI read strobe (side effects only)
// - reg_addr   in   7   DMI register address
// - reg_wdata  in   32  DMI write data
// - reg_rdata  out  32  combinational read mux: sbcs/sbaddress0/sbdata0; 0 for any other address
// - sb_req     out  1   bus request; held until sb_gnt
// - sb_we      out  1   1=write, 0=read; stable while sb_req
// - sb_addr    out  AW  byte address; stable while sb_req
// - sb_be      out  4   byte enables from size and addr[1:0]
// - sb_wdata   out  32  write data, replicated across byte lanes
// - sb_gnt     in   1   request accepted this cycle
// - sb_rvalid  in   1   response valid (read data or write ack); earliest 1 cycle after gnt
// - sb_rdata   in   32  read data, full word
// - sb_err     in   1   bus error, qualified by sb_rvalid
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; sbaddress0 = 0; sbdata0 = 0; all writable sbcs fields = 0
//   except sbaccess = 2 (32-bit). Reset mid-transaction aborts immediately: sb_req drops, no retry.
// - sbcs layout:
//   [31:29] sbversion = 1;  [22] sbbusyerror, W1C;  [21] sbbusy, RO, = (state != IDLE)
//   [20] sbreadonaddr;  [19:17] sbaccess;  [16] sbautoincrement;  [15] sbreadondata
//   [14:12] sberror, W1C per bit;  [11:5] sbasize = AW;  [2:0] = 3'b111 (8/16/32 supported)
//   All other bits read 0.
// - FSM:
//   IDLE --start--> REQ
//   REQ --sb_gnt--> RSP
//   RSP --sb_rvalid--> IDLE (completion updates applied on the same edge)
// - Start conditions (only when sbbusyerror == 0 and sberror == 0):
//   - write to sbdata0 -> write access
//   - write to sbaddress0 with sbreadonaddr = 1 -> read access
//   - read of sbdata0 with sbreadondata = 1 -> read access
// - Start latency: sb_req asserts the cycle after the triggering strobe; address/data are
//   captured from sbaddress0/sbdata0 as updated by that strobe.
// - Pre-checks at start; on failure no bus cycle, state stays IDLE:
//   - sbaccess > 2 -> sberror = 4
//   - misaligned address -> sberror = 3 (sbaccess 1: addr[0] != 0; sbaccess 2: addr[1:0] != 0)
// - Busy rule: reg_wr to 0x39/0x3C, or reg_rd of 0x3C, while sbbusy = 1:
//   - sbbusyerror = 1; the write is discarded; no new access starts
//   - reg_rdata still returns the current register value
//   - the completion cycle itself still counts as busy
// - sbcs writes are always accepted: W1C fields clear, control fields update, even while busy.
// - Read completion: sbdata0 = sb_rdata shifted right by 8*addr[1:0], zero-extended to the access size.
// - Completion with sb_err = 1:
//   - sberror = 2; sbdata0 unchanged; no autoincrement
// - Completion without error and sbautoincrement = 1:
//   - sbaddress0 += (1 << sbaccess), modulo 2^AW (wraps to 0)
// - Read-on-data order: reg_rdata returns the old sbdata0; the triggered read loads the next value.
//   Autoincrement follows that read.
// - sb_be:
//   - 8-bit: 4'b0001 << addr[1:0]
//   - 16-bit: 4'b0011 << addr[1:0]
//   - 32-bit: 4'b1111
// - Simultaneous reg_wr and reg_rd in one cycle is illegal (DMI serialises); the write takes priority.
// TESTING
// - 32-bit write, no gnt stall:
//   sbaddress0=0x8000_0000, sbdata0=0xDEADBEEF -> sb_req/we=1, be=4'hF, addr=0x8000_0000;
//   after rvalid, sbbusy=0.
// - Byte read with sbreadonaddr=1, sbaccess=0, addr 0x103, bus returns 0xAABBCCDD
//   -> be=4'b1000; sbdata0=0x0000_00AA.
// - Autoincrement + readondata, sbaccess=2, start addr 0x200:
//   three reads of 0x3C -> bus reads at 0x200, 0x204, 0x208; sbaddress0 ends at 0x20C.
// - Write sbdata0 while busy (gnt held low 5 cycles)
//   -> sbbusyerror=1, single bus transaction, sbdata0 unchanged;
//   W1C 1<<22 clears it; the next access works.
// - Error paths:
//   - sbaccess=3 -> sberror=4, no sb_req
//   - 16-bit at 0x101 -> sberror=3
//   - sb_err on rvalid -> sberror=2 and no autoincrement
//   - while sberror != 0, writes start nothing
// - Assert rst while in RSP -> sb_req=0 and state IDLE immediately; sbcs reads 0x2000_0000|(AW<<5)|0x4_0007.

Source files
------------

// File: rtl/dm_sba_if.sv
// DMI register port and system bus bundle for the debug-module SBA block.
// master: the SBA controller; slave: the DMI host plus the bus target.
interface dm_sba_if #(
  parameter int AW = 32
);
  logic          reg_wr;
  logic          reg_rd;
  logic [6:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          sb_req;
  logic          sb_we;
  logic [AW-1:0] sb_addr;
  logic [3:0]    sb_be;
  logic [31:0]   sb_wdata;
  logic          sb_gnt;
  logic          sb_rvalid;
  logic [31:0]   sb_rdata;
  logic          sb_err;

  modport master (
    input  reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata,
    output sb_req, sb_we, sb_addr, sb_be, sb_wdata,
    input  sb_gnt, sb_rvalid, sb_rdata, sb_err
  );

  modport slave (
    output reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata,
    input  sb_req, sb_we, sb_addr, sb_be, sb_wdata,
    output sb_gnt, sb_rvalid, sb_rdata, sb_err
  );
endinterface

// File: rtl/dm_sba.sv
// Debug-module system bus access: sbcs/sbaddress0/sbdata0 plus a single
// outstanding req/gnt/rvalid bus cycle. Ports: clk, rst (async high), bus.
module dm_sba #(
  parameter int AW = 32
) (
  input  logic     clk,
  input  logic     rst,
  dm_sba_if.master bus
);

  localparam logic [6:0] A_CS   = 7'h38;
  localparam logic [6:0] A_ADDR = 7'h39;
  localparam logic [6:0] A_DATA = 7'h3C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [AW-1:0] r_addr;
  logic [31:0]   r_data;
  logic          r_busyerr;
  logic          r_rdonaddr;
  logic [2:0]    r_access;
  logic          r_autoinc;
  logic          r_rdondata;
  logic [2:0]    r_err;
  logic          r_we;
  logic [AW-1:0] r_baddr;
  logic [1:0]    r_sz;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;

  logic          w_busy;
  logic          w_wr_cs;
  logic          w_wr_addr;
  logic          w_wr_data;
  logic          w_rd_data;
  logic          w_viol;
  logic          w_ok;
  logic          w_go_wr;
  logic          w_go_rd;
  logic          w_go;
  logic          w_bad_size;
  logic          w_misal;
  logic          w_launch;
  logic          w_done;
  logic [AW-1:0] w_naddr;
  logic [31:0]   w_ndata;
  logic [3:0]    w_be;
  logic [31:0]   w_wrep;
  logic [31:0]   w_shift;
  logic [31:0]   w_rext;
  logic [AW-1:0] w_step;
  logic [31:0]   w_sbcs;
  logic [31:0]   w_rdata;
  logic          w_sel_cs;
  logic          w_sel_addr;
  logic          w_sel_data;

  assign w_busy    = (r_state != S_IDLE);
  assign w_wr_cs   = bus.reg_wr && (bus.reg_addr == A_CS);
  assign w_wr_addr = bus.reg_wr && (bus.reg_addr == A_ADDR);
  assign w_wr_data = bus.reg_wr && (bus.reg_addr == A_DATA);
  // a write in the same cycle wins over the read strobe
  assign w_rd_data = bus.reg_rd && !bus.reg_wr
                  && (bus.reg_addr == A_DATA);

  assign w_viol = w_busy && (w_wr_addr || w_wr_data || w_rd_data);
  assign w_ok   = !w_busy && !r_busyerr && (r_err == 3'd0);

  assign w_go_wr = w_ok && w_wr_data;
  assign w_go_rd = w_ok && ((w_wr_addr && r_rdonaddr)
                         || (w_rd_data && r_rdondata));
  assign w_go    = w_go_wr || w_go_rd;

  // bus cycle sees the register values as updated by the same strobe
  assign w_naddr = w_wr_addr ? bus.reg_wdata[AW-1:0] : r_addr;
  assign w_ndata = w_wr_data ? bus.reg_wdata : r_data;

  assign w_bad_size = (r_access > 3'd2);
  assign w_misal    = ((r_access == 3'd1) && w_naddr[0])
                   || ((r_access == 3'd2) && (w_naddr[1:0] != 2'd0));
  assign w_launch   = w_go && !w_bad_size && !w_misal;
  assign w_done     = (r_state == S_RSP) && bus.sb_rvalid;

  always_comb begin
    w_be   = 4'b1111;
    w_wrep = w_ndata;
    unique case (r_access[1:0])
      2'd0: begin
        w_be   = 4'b0001 << w_naddr[1:0];
        w_wrep = {4{w_ndata[7:0]}};
      end
      2'd1: begin
        w_be   = 4'b0011 << w_naddr[1:0];
        w_wrep = {2{w_ndata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = bus.sb_rdata >> {r_baddr[1:0], 3'b000};

  always_comb begin
    w_rext = w_shift;
    unique case (r_sz)
      2'd0:    w_rext = {24'd0, w_shift[7:0]};
      2'd1:    w_rext = {16'd0, w_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_step      = '0;
    w_step[2:0] = 3'd1 << r_sz;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_launch)      w_next = S_REQ;
      S_REQ:   if (bus.sb_gnt)    w_next = S_RSP;
      S_RSP:   if (bus.sb_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_busyerr  <= 1'b0;
      r_rdonaddr <= 1'b0;
      r_access   <= 3'd2;
      r_autoinc  <= 1'b0;
      r_rdondata <= 1'b0;
      r_err      <= 3'd0;
      r_we       <= 1'b0;
      r_baddr    <= '0;
      r_sz       <= 2'd0;
      r_be       <= 4'd0;
      r_wdata    <= '0;
    end else begin
      if (w_wr_cs) begin
        r_busyerr  <= r_busyerr & ~bus.reg_wdata[22];
        r_rdonaddr <= bus.reg_wdata[20];
        r_access   <= bus.reg_wdata[19:17];
        r_autoinc  <= bus.reg_wdata[16];
        r_rdondata <= bus.reg_wdata[15];
        r_err      <= r_err & ~bus.reg_wdata[14:12];
      end
      if (w_viol)                r_busyerr <= 1'b1;
      if (!w_busy && w_wr_addr)  r_addr    <= w_naddr;
      if (!w_busy && w_wr_data)  r_data    <= bus.reg_wdata;
      if (w_go && w_bad_size)    r_err     <= 3'd4;
      else if (w_go && w_misal)  r_err     <= 3'd3;
      if (w_launch) begin
        r_we    <= w_go_wr;
        r_baddr <= w_naddr;
        r_sz    <= r_access[1:0];
        r_be    <= w_be;
        r_wdata <= w_wrep;
      end
      if (w_done) begin
        if (bus.sb_err) begin
          r_err <= 3'd2;
        end else begin
          if (!r_we)     r_data <= w_rext;
          if (r_autoinc) r_addr <= r_addr + w_step;
        end
      end
    end
  end

  assign w_sbcs = {3'd1, 6'd0, r_busyerr, w_busy, r_rdonaddr,
                   r_access, r_autoinc, r_rdondata, r_err,
                   7'(AW), 2'b00, 3'b111};

  assign w_sel_cs   = (bus.reg_addr == A_CS);
  assign w_sel_addr = (bus.reg_addr == A_ADDR);
  assign w_sel_data = (bus.reg_addr == A_DATA);

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_cs:   w_rdata = w_sbcs;
      w_sel_addr: w_rdata = 32'(r_addr);
      w_sel_data: w_rdata = r_data;
      default:    ;
    endcase
  end

  assign bus.reg_rdata = w_rdata;
  assign bus.sb_req    = (r_state == S_REQ);
  assign bus.sb_we     = r_we;
  assign bus.sb_addr   = r_baddr;
  assign bus.sb_be     = r_be;
  assign bus.sb_wdata  = r_wdata;

endmodule

// File: tb/tb_dm_sba.sv
// Directed and randomized bench for dm_sba with a behavioural bus target
// and register model.
module tb_dm_sba;
  localparam int AW = 32;
  localparam logic [6:0] A_CS   = 7'h38;
  localparam logic [6:0] A_ADDR = 7'h39;
  localparam logic [6:0] A_DATA = 7'h3C;
  localparam logic [31:0] CS_RST = 32'h2000_0000 | (32'd32 << 5) | 32'h4_0007;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_sba_if #(.AW(AW)) bus();
  dm_sba #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t txq[$];
  logic [31:0] mem [logic [31:0]];
  int gnt_dly  = 0;
  int rsp_dly  = 0;
  bit err_next = 0;

  function automatic logic [31:0] rdword(input logic [31:0] a);
    logic [31:0] k;
    k = a >> 2;
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  // bus target: optional grant stall, fixed response delay
  initial begin : resp
    bit seen, pend, re;
    int gl, rl;
    logic [31:0] rd, w;
    seen = 0; pend = 0; re = 0; gl = 0; rl = 0; rd = '0;
    bus.sb_gnt = 0; bus.sb_rvalid = 0; bus.sb_rdata = '0; bus.sb_err = 0;
    forever begin
      @(negedge clk);
      bus.sb_gnt = 0; bus.sb_rvalid = 0; bus.sb_err = 0;
      if (rst) begin
        seen = 0; pend = 0;
      end else if (pend) begin
        if (rl == 0) begin
          bus.sb_rvalid = 1; bus.sb_rdata = rd; bus.sb_err = re; pend = 0;
        end else rl--;
      end else if (bus.sb_req) begin
        if (!seen) begin seen = 1; gl = gnt_dly; end
        if (gl == 0) begin
          bus.sb_gnt = 1; seen = 0; pend = 1; rl = rsp_dly;
          re = err_next; err_next = 0;
          txq.push_back('{bus.sb_we, bus.sb_addr, bus.sb_be, bus.sb_wdata});
          w = rdword(bus.sb_addr);
          if (bus.sb_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.sb_be[b]) w[8*b +: 8] = bus.sb_wdata[8*b +: 8];
            mem[bus.sb_addr >> 2] = w;
            rd = '0;
          end else rd = w;
        end else gl--;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic dwr(input logic [6:0] a, input logic [31:0] d);
    bus.reg_wr = 1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_wr = 0;
  endtask

  task automatic drd(input logic [6:0] a, output logic [31:0] d);
    bus.reg_rd = 1; bus.reg_addr = a;
    #1 d = bus.reg_rdata;
    @(negedge clk);
    bus.reg_rd = 0;
  endtask

  task automatic peek(input logic [6:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1 d = bus.reg_rdata;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] v;
    peek(A_CS, v);
    for (int k = 0; k < 300 && v[21]; k++) begin
      @(negedge clk);
      peek(A_CS, v);
    end
    chk(tag, 32'(v[21]), 32'd0);
  endtask

  function automatic logic [31:0] cs_exp(bit be_, bit roa, int acc,
                                         bit ai, bit rod, int er);
    return 32'h2000_0000 + (be_ ? 32'h40_0000 : 0) + (roa ? 32'h10_0000 : 0)
         + 32'(acc) * 32'h2_0000 + (ai ? 32'h1_0000 : 0)
         + (rod ? 32'h8000 : 0) + 32'(er) * 32'h1000 + 32'd32 * 32 + 7;
  endfunction

  initial begin : main
    logic [31:0] v, d, a, m_data, m_addr, exp_d, exp_a, word;
    int sz, off, n0;
    bit wr, ai, er;

    rst = 1;
    bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_addr = '0; bus.reg_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 0;

    // reset state
    peek(A_CS, v);   chk("rst_sbcs", v, CS_RST);
    peek(A_ADDR, v); chk("rst_addr", v, 0);
    peek(A_DATA, v); chk("rst_data", v, 0);
    chk("rst_req", 32'(bus.sb_req), 0);
    chk("rst_be", 32'(bus.sb_be), 0);
    peek(7'h10, v);  chk("other_addr", v, 0);

    // 32-bit write
    dwr(A_ADDR, 32'h8000_0000);
    dwr(A_DATA, 32'hDEAD_BEEF);
    chk("w32_req", 32'(bus.sb_req), 1);
    chk("w32_we", 32'(bus.sb_we), 1);
    chk("w32_be", 32'(bus.sb_be), 32'hF);
    chk("w32_addr", bus.sb_addr, 32'h8000_0000);
    chk("w32_wdata", bus.sb_wdata, 32'hDEAD_BEEF);
    wait_idle("w32_idle");
    chk("w32_ntx", txq.size(), 1);
    peek(A_CS, v); chk("w32_sbcs", v, cs_exp(0, 0, 2, 0, 0, 0));
    txq.delete();

    // byte read on address write
    mem[32'h100 >> 2] = 32'hAABB_CCDD;
    dwr(A_CS, 32'h10_0000);
    dwr(A_ADDR, 32'h103);
    chk("rb_req", 32'(bus.sb_req), 1);
    chk("rb_we", 32'(bus.sb_we), 0);
    chk("rb_be", 32'(bus.sb_be), 32'h8);
    wait_idle("rb_idle");
    peek(A_DATA, v); chk("rb_data", v, 32'hAA);
    txq.delete();

    // autoincrement with read-on-data
    dwr(A_CS, 32'h4_0000 | 32'h1_0000 | 32'h8000);
    dwr(A_ADDR, 32'h200);
    peek(A_CS, v); chk("ai_nostart", 32'(v[21]), 0);
    m_data = 32'hAA;
    for (int i = 0; i < 3; i++) begin
      drd(A_DATA, v);
      chk("ai_old", v, m_data);
      wait_idle("ai_idle");
      m_data = mem[(32'h200 + 4 * i) >> 2];
    end
    chk("ai_ntx", txq.size(), 3);
    for (int i = 0; i < 3 && i < txq.size(); i++)
      chk("ai_txaddr", txq[i].addr, 32'h200 + 4 * i);
    dwr(A_CS, 32'h4_0000);
    peek(A_DATA, v); chk("ai_data", v, m_data);
    peek(A_ADDR, v); chk("ai_addr", v, 32'h20C);
    txq.delete();

    // busy violation
    dwr(A_ADDR, 32'h300);
    gnt_dly = 5;
    dwr(A_DATA, 32'h1111_1111);
    dwr(A_DATA, 32'h2222_2222);
    peek(A_DATA, v); chk("bz_rdata", v, 32'h1111_1111);
    wait_idle("bz_idle");
    gnt_dly = 0;
    chk("bz_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("bz_wd", txq[0].wdata, 32'h1111_1111);
    peek(A_DATA, v); chk("bz_data", v, 32'h1111_1111);
    peek(A_CS, v); chk("bz_sbcs", v, cs_exp(1, 0, 2, 0, 0, 0));
    dwr(A_DATA, 32'h5555_5555);
    chk("bz_blocked", 32'(bus.sb_req), 0);
    dwr(A_CS, 32'h40_0000 | 32'h4_0000);
    peek(A_CS, v); chk("bz_w1c", v, cs_exp(0, 0, 2, 0, 0, 0));
    dwr(A_DATA, 32'h3333_3333);
    wait_idle("bz_idle2");
    chk("bz_ntx2", txq.size(), 2);
    if (txq.size() > 1) chk("bz_wd2", txq[1].wdata, 32'h3333_3333);
    txq.delete();

    // error paths
    dwr(A_CS, 32'h6_0000);
    dwr(A_DATA, 32'h77);
    chk("e4_req", 32'(bus.sb_req), 0);
    peek(A_CS, v); chk("e4_sbcs", v, cs_exp(0, 0, 3, 0, 0, 4));
    dwr(A_CS, 32'h7000 | 32'h2_0000);
    dwr(A_ADDR, 32'h101);
    dwr(A_DATA, 32'h88);
    chk("e3_req", 32'(bus.sb_req), 0);
    peek(A_CS, v); chk("e3_sbcs", v, cs_exp(0, 0, 1, 0, 0, 3));
    dwr(A_CS, 32'h7000 | 32'h4_0000 | 32'h1_0000);
    dwr(A_ADDR, 32'h400);
    err_next = 1;
    dwr(A_DATA, 32'h99);
    wait_idle("e2_idle");
    peek(A_CS, v); chk("e2_sbcs", v, cs_exp(0, 0, 2, 1, 0, 2));
    peek(A_ADDR, v); chk("e2_noinc", v, 32'h400);
    n0 = txq.size();
    dwr(A_DATA, 32'hAB);
    repeat (3) @(negedge clk);
    chk("e2_nostart", txq.size(), n0);
    dwr(A_CS, 32'h7000 | 32'h4_0000);
    txq.delete();

    // randomized single accesses against the model
    m_data = 32'hAB;
    for (int it = 0; it < 40; it++) begin
      sz  = $urandom_range(0, 2);
      off = (sz == 0) ? $urandom_range(0, 3)
          : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
      a   = 32'h1000 + ($urandom_range(0, 255) << 2) + off;
      wr  = $urandom_range(0, 1) == 1;
      ai  = $urandom_range(0, 1) == 1;
      er  = $urandom_range(0, 7) == 0;
      d   = $urandom;
      gnt_dly = $urandom_range(0, 3);
      rsp_dly = $urandom_range(0, 3);
      err_next = er;
      dwr(A_CS, (wr ? 0 : 32'h10_0000) | 32'(sz) * 32'h2_0000
                | (ai ? 32'h1_0000 : 0));
      dwr(A_ADDR, a);
      if (wr) dwr(A_DATA, d);
      wait_idle("rnd_idle");
      chk("rnd_ntx", txq.size(), 1);
      if (txq.size() > 0) begin
        chk("rnd_we", 32'(txq[0].we), 32'(wr));
        chk("rnd_addr", txq[0].addr, a);
        chk("rnd_be", 32'(txq[0].be),
            (sz == 0) ? (1 << off) : (sz == 1) ? (3 << off) : 15);
        if (wr)
          chk("rnd_wd", txq[0].wdata,
              (sz == 0) ? d[7:0] * 32'h0101_0101
            : (sz == 1) ? d[15:0] * 32'h0001_0001 : d);
      end
      word = rdword(a);
      if (wr) m_data = d;
      if (!wr && !er)
        m_data = (word >> (8 * off)) &
                 ((sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF);
      exp_a = (ai && !er) ? a + (1 << sz) : a;
      exp_d = m_data;
      peek(A_DATA, v); chk("rnd_data", v, exp_d);
      peek(A_ADDR, v); chk("rnd_sbaddr", v, exp_a);
      peek(A_CS, v);
      chk("rnd_sbcs", v, cs_exp(0, !wr, sz, ai, 0, er ? 2 : 0));
      if (er) dwr(A_CS, 32'h7000);
      txq.delete();
    end
    gnt_dly = 0;
    rsp_dly = 0;

    // reset while requesting
    dwr(A_CS, 32'h4_0000);
    dwr(A_ADDR, 32'h500);
    gnt_dly = 4;
    dwr(A_DATA, 32'h1);
    chk("rq_req", 32'(bus.sb_req), 1);
    rst = 1;
    #1 chk("rq_rst_req", 32'(bus.sb_req), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    gnt_dly = 0;

    // reset while waiting for the response
    rsp_dly = 8;
    dwr(A_DATA, 32'h2);
    repeat (2) @(negedge clk);
    peek(A_CS, v); chk("rs_busy", 32'(v[21]), 1);
    rst = 1;
    #1;
    peek(A_CS, v); chk("rs_sbcs", v, CS_RST);
    chk("rs_req", 32'(bus.sb_req), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    rsp_dly = 0;
    txq.delete();
    dwr(A_DATA, 32'h3);
    wait_idle("post_idle");
    chk("post_ntx", txq.size(), 1);
    if (txq.size() > 0) chk("post_wd", txq[0].wdata, 32'h3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
